// File: rtl/reg_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x32 register file.
// Arbitrates the single write port between the ALU and LSU result
// sources. Tracks which destination registers are still in flight and
// stalls issue on RAW/WAW hazards. Register x0 is never tracked.
module reg_wb_sched #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [5:0]      busy_cnt,
    output logic            orphan_err
);

    logic [31:0]     busy_reg;
    logic [31:0]     busy_next;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;
    logic [5:0]      busy_cnt_reg;
    logic [5:0]      busy_cnt_next;
    logic            wb_we_reg;
    logic [4:0]      wb_addr_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic            orphan_reg;
    logic            last_lsu_reg;   // 1 = LSU received the most recent grant

    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            accept;
    logic            alu_wins;
    logic            gnt_alu;
    logic            gnt_lsu;
    logic            gnt_any;
    logic [4:0]      rd_g;
    logic [XLEN-1:0] data_g;
    logic            orphan_hit;
    logic            cnt_inc;
    logic            cnt_dec;

    // Hazard detection: a busy non-zero register blocks issue
    assign hit_rs1   = (iss_rs1 != 5'd0) & busy_reg[iss_rs1];
    assign hit_rs2   = (iss_rs2 != 5'd0) & busy_reg[iss_rs2];
    assign hit_rd    = (iss_rd  != 5'd0) & busy_reg[iss_rd];
    assign iss_stall = iss_valid & (hit_rs1 | hit_rs2 | hit_rd);
    assign accept    = iss_valid & ~iss_stall & ~rst;

    // Arbitration: under contention, round-robin hands the grant to the
    // source that was not served last; fixed priority always picks the LSU
    assign alu_wins  = RR_EN ? last_lsu_reg : 1'b0;
    assign gnt_alu   = ~rst & alu_valid & (~lsu_valid | alu_wins);
    assign gnt_lsu   = ~rst & lsu_valid & (~alu_valid | ~alu_wins);
    assign gnt_any   = gnt_alu | gnt_lsu;
    assign alu_ready = gnt_alu;
    assign lsu_ready = gnt_lsu;
    assign rd_g      = gnt_lsu ? lsu_rd   : alu_rd;
    assign data_g    = gnt_lsu ? lsu_data : alu_data;

    assign orphan_hit = gnt_any & (rd_g != 5'd0) & ~busy_reg[rd_g];

    // Per-register set/clear; a set on the same edge as a clear wins
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign set_vec[gi]   = 1'b0;
                assign clr_vec[gi]   = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign set_vec[gi]   = accept & (iss_rd == 5'(gi));
                assign clr_vec[gi]   = wb_we_reg & (wb_addr_reg == 5'(gi));
                assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    // Counter tracks the popcount incrementally: count only real transitions
    assign cnt_inc       = |(set_vec & ~busy_reg);
    assign cnt_dec       = |(clr_vec & busy_reg & ~set_vec);
    assign busy_cnt_next = busy_cnt_reg + {5'd0, cnt_inc} - {5'd0, cnt_dec};

    // Scoreboard, write-back register stage, arbiter history and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
            wb_we_reg    <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
            orphan_reg   <= 1'b0;
            last_lsu_reg <= 1'b1;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
            if (gnt_any) begin
                wb_we_reg    <= (rd_g != 5'd0);
                wb_addr_reg  <= rd_g;
                wb_data_reg  <= data_g;
                last_lsu_reg <= gnt_lsu;
            end else begin
                wb_we_reg    <= 1'b0;
            end
            if (orphan_hit) begin
                orphan_reg <= 1'b1;
            end
        end
    end

    assign wb_we      = wb_we_reg;
    assign wb_addr    = wb_addr_reg;
    assign wb_data    = wb_data_reg;
    assign busy_cnt   = busy_cnt_reg;
    assign orphan_err = orphan_reg;

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file, whose write port has RegWEn, AddrD and DataD and whose x0 always reads zero.
- Arbitrates the single write port between two write-back sources: ALU and LSU.
- Tracks in-flight destination registers and produces the issue-stage stall for RAW/WAW hazards.
- Sits between decode/issue, the execution units and the register file write port.

Parameters:
XLEN, 32, data width of write-back data.
RR_EN, 1, 1 = round-robin between ALU/LSU; 0 = fixed priority, LSU wins.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous active-high reset.
iss_valid  input  1  issue stage presents an instruction.
iss_rd  input  5  destination register of issuing instruction.
iss_rs1  input  5  source register 1.
iss_rs2  input  5  source register 2.
iss_stall  output  1  combinational; instruction must not issue this cycle.
alu_valid  input  1  ALU result available.
alu_rd  input  5  ALU destination.
alu_data  input  XLEN  ALU result.
alu_ready  output  1  combinational; ALU result consumed this cycle.
lsu_valid  input  1  load result available.
lsu_rd  input  5  load destination.
lsu_data  input  XLEN  load data.
lsu_ready  output  1  combinational; LSU result consumed this cycle.
wb_we  output  1  registered; drives register file RegWEn.
wb_addr  output  5  registered; drives AddrD.
wb_data  output  XLEN  registered; drives DataD.
busy_cnt  output  6  registered; number of busy registers, 0..31.
orphan_err  output  1  sticky; a write-back targeted a non-busy register.

Behaviour:
- Reset (rst=1 at posedge):
  - busy[31:0] = 0, busy_cnt = 0, wb_we = 0, wb_addr = 0, wb_data = 0, orphan_err = 0.
  - last_grant = LSU, so the first contended grant under RR goes to ALU.
  - Reset mid-operation drops any pending write and all busy bits. ready outputs are 0 during the rst cycle.
- Stall:
  - iss_stall = iss_valid & (hit(rs1) | hit(rs2) | hit(rd)), where hit(r) = (r != 0) & busy[r].
  - x0 never stalls.
- Issue accept:
  - Accept occurs when iss_valid & !iss_stall & !rst.
  - At that edge busy[iss_rd] <= 1 if iss_rd != 0.
- Arbitration (combinational):
  - Only one source valid: that source is granted.
  - Both valid, RR_EN=1: grant the source not in last_grant. RR_EN=0: grant LSU.
  - ready of the granted source = 1; ready of the other source = 0.
  - A source holds valid/rd/data stable until it sees ready.
  - last_grant updates only when a grant occurs.
- Write-back latency: 1 cycle.
  - At the grant edge: wb_we <= (rd_g != 0), wb_addr <= rd_g, wb_data <= data_g.
  - With no grant: wb_we <= 0; wb_addr/wb_data hold.
  - A grant with rd = 0 is consumed, but wb_we stays 0.
- Busy clear:
  - At the edge ending a cycle with wb_we = 1, busy[wb_addr] <= 0.
  - This is the same edge at which the register file writes, so a stalled reader issues the next cycle and reads the new value.
  - If set and clear hit the same register at one edge, set wins. This cannot arise from legal issue, because the register is still busy during the wb_we cycle.
- Orphan:
  - Grant with rd_g != 0 and busy[rd_g] = 0 sets orphan_err = 1, held until rst.
  - The write still proceeds.
- busy_cnt:
  - Equals popcount(busy) after every edge: +1 on a set, -1 on a clear, net 0 when both occur on different registers.
  - Never wraps; at most 31 registers can be busy.
- Back-to-back grants on consecutive cycles are allowed: throughput is 1 write per cycle.

Test Plan:
- Reset, then issue rd=5 (rs1=rs2=0) -> busy_cnt=1. Next issue with rs1=5 -> iss_stall=1. ALU wb rd=5, data=0xDEADBEEF -> alu_ready=1 that cycle; next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF. Cycle after: iss_stall=0, busy_cnt=0.
- Issue rd=3 and rd=4, then ALU(rd=3) and LSU(rd=4) valid together for 2 cycles, RR_EN=1 -> cycle 1 alu_ready=1, lsu_ready=0; cycle 2 lsu_ready=1. wb_addr sequence 3 then 4, busy_cnt 2->1->0.
- Same contention with RR_EN=0 -> LSU granted first. ALU is granted only once lsu_valid drops.
- LSU wb rd=0, data=0x1234 -> lsu_ready=1, wb_we stays 0, busy_cnt unchanged, orphan_err stays 0. Issue with rs1=0, rd=0 never stalls.
- ALU wb rd=7 with busy[7]=0 -> write occurs (wb_we=1, wb_addr=7), orphan_err=1 and stays 1 until rst.
- Issue rd=9 and rd=10, grant ALU rd=9, assert rst in the cycle wb_we would rise -> after reset wb_we=0, busy_cnt=0, iss_stall=0 for rs1=10.
